// File: rtl/avalon_mm_regbank_pkg.sv
// avalon_mm_regbank_pkg: word offsets and helpers shared by the register bank
package avalon_mm_regbank_pkg;

    localparam int ID_IDX        = 0;
    localparam int EVENT_IDX     = 1;
    localparam int MASK_IDX      = 2;
    localparam int CTRL_BASE_IDX = 3;

    function automatic int stat_base_idx(input int num_ctrl);
        return CTRL_BASE_IDX + num_ctrl;
    endfunction

    function automatic logic [7:0] apply_byteen(input logic [7:0] old_v, input logic [7:0] new_v, input logic be);
        return be ? new_v : old_v;
    endfunction

endpackage

// File: rtl/avalon_mm_rdpipe.sv
// avalon_mm_rdpipe: fixed-latency read return pipeline holding the last delivered data
module avalon_mm_rdpipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [LATENCY-1:0]                 valid_q;
    logic [LATENCY-1:0][DATA_WIDTH-1:0] data_q;

    // shift valid every cycle; data stages only load behind a valid so the output holds between reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q[0] <= valid_i;
            if (valid_i) data_q[0] <= data_i;
            for (int s = 1; s < LATENCY; s++) begin
                valid_q[s] <= valid_q[s-1];
                if (valid_q[s-1]) data_q[s] <= data_q[s-1];
            end
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/avalon_mm_regbank.sv
// avalon_mm_regbank: Avalon-MM window with ID, W1C event/mask, control and status registers
module avalon_mm_regbank
    import avalon_mm_regbank_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h11223340,
    parameter int          NUM_CTRL     = 4,
    parameter int          NUM_STAT     = 2,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] ID_VALUE     = 32'hBE0C0001,
    localparam int         BE_WIDTH     = DATA_WIDTH / 8,
    localparam int         STAT_W       = (NUM_STAT > 0 ? NUM_STAT : 1) * DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [31:0]                    avs_address,
    input  logic [BE_WIDTH-1:0]            avs_byteenable,
    input  logic                           avs_read,
    input  logic                           avs_write,
    input  logic [DATA_WIDTH-1:0]          avs_writedata,
    output logic [DATA_WIDTH-1:0]          avs_readdata,
    output logic                           avs_readdatavalid,
    output logic                           avs_waitrequest,
    output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_q,
    output logic [NUM_CTRL-1:0]            ctrl_wr,
    input  logic [STAT_W-1:0]              status_d,
    input  logic [DATA_WIDTH-1:0]          event_in,
    output logic                           irq
);

    localparam int STAT_BASE = stat_base_idx(NUM_CTRL);
    localparam int NUM_WORDS = STAT_BASE + NUM_STAT;

    logic [31:0]                    offset, idx;
    logic                           hit, rd_acc, wr_hit;
    logic [DATA_WIDTH-1:0]          event_q, event_d, mask_q, mask_d, clr, rdata_d;
    logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_d;
    logic [NUM_CTRL-1:0]            ctrl_wr_d;

    assign rd_acc = avs_read & ~avs_waitrequest;
    assign offset = avs_address - BASE_ADDR;
    assign idx    = offset / 32'(BE_WIDTH);
    assign hit    = (avs_address >= BASE_ADDR) && ((offset % 32'(BE_WIDTH)) == '0) && (idx < 32'(NUM_WORDS));
    assign wr_hit = avs_write & ~avs_waitrequest & hit;

    // read mux over the pre-write register values; misses read as zero
    always_comb begin
        rdata_d = '0;
        if (hit && idx == 32'(ID_IDX))    rdata_d = DATA_WIDTH'(ID_VALUE);
        if (hit && idx == 32'(EVENT_IDX)) rdata_d = event_q;
        if (hit && idx == 32'(MASK_IDX))  rdata_d = mask_q;
        for (int k = 0; k < NUM_CTRL; k++)
            if (hit && idx == 32'(CTRL_BASE_IDX + k)) rdata_d = ctrl_q[k*DATA_WIDTH +: DATA_WIDTH];
        for (int k = 0; k < NUM_STAT; k++)
            if (hit && idx == 32'(STAT_BASE + k)) rdata_d = status_d[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // byte-lane write merge; event clear mask only in enabled lanes, new events win over clears
    always_comb begin
        mask_d    = mask_q;
        ctrl_d    = ctrl_q;
        clr       = '0;
        ctrl_wr_d = '0;
        for (int b = 0; b < BE_WIDTH; b++) begin
            if (wr_hit && idx == 32'(EVENT_IDX))
                clr[b*8 +: 8] = apply_byteen(8'h00, avs_writedata[b*8 +: 8], avs_byteenable[b]);
            if (wr_hit && idx == 32'(MASK_IDX))
                mask_d[b*8 +: 8] = apply_byteen(mask_q[b*8 +: 8], avs_writedata[b*8 +: 8], avs_byteenable[b]);
            for (int k = 0; k < NUM_CTRL; k++)
                if (wr_hit && idx == 32'(CTRL_BASE_IDX + k))
                    ctrl_d[(k*BE_WIDTH + b)*8 +: 8] = apply_byteen(ctrl_q[(k*BE_WIDTH + b)*8 +: 8],
                                                                   avs_writedata[b*8 +: 8], avs_byteenable[b]);
        end
        for (int k = 0; k < NUM_CTRL; k++)
            ctrl_wr_d[k] = wr_hit && idx == 32'(CTRL_BASE_IDX + k) && |avs_byteenable;
        event_d = (event_q & ~clr) | event_in;
    end

    // register state; waitrequest comes out of reset high and drops after the first edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_waitrequest <= 1'b1;
            event_q         <= '0;
            mask_q          <= '0;
            ctrl_q          <= '0;
            ctrl_wr         <= '0;
            irq             <= 1'b0;
        end else begin
            avs_waitrequest <= 1'b0;
            event_q         <= event_d;
            mask_q          <= mask_d;
            ctrl_q          <= ctrl_d;
            ctrl_wr         <= ctrl_wr_d;
            irq             <= |(event_q & mask_q);
        end
    end

    avalon_mm_rdpipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_rdpipe (
        .clk     (clk),
        .reset_n (reset_n),
        .valid_i (rd_acc),
        .data_i  (rdata_d),
        .valid_o (avs_readdatavalid),
        .data_o  (avs_readdata)
    );

endmodule

// File: tb/tb_avalon_mm_regbank.sv
// tb_avalon_mm_regbank: directed and random checks of three latency variants against a word-level model
module tb_avalon_mm_regbank;

    localparam logic [31:0] BASE = 32'h11223340;
    localparam logic [31:0] ID   = 32'hBE0C0001;

    logic         clk, reset_n, avs_read, avs_write;
    logic [31:0]  avs_address, avs_writedata, event_in;
    logic [3:0]   avs_byteenable;
    logic [63:0]  status_d;

    logic         rdv1, rdv2, rdv3, wq1, wq2, wq3, irq1, irq2, irq3;
    logic [31:0]  rdd1, rdd2, rdd3;
    logic [3:0]   cw1, cw2, cw3;
    logic [127:0] cq1, cq2, cq3;

    int ncmp = 0, nerr = 0, cyc = 0;

    logic [31:0]       m_event, m_mask;
    logic [3:0][31:0]  m_ctrl;
    logic [3:0]        m_wr;
    logic              m_irq, m_wait;
    bit                hv[2048];
    logic [31:0]       hd[2048];
    logic [31:0]       m_rd[1:3];

    avalon_mm_regbank #(.READ_LATENCY(1)) u1 (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_byteenable(avs_byteenable),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(rdd1), .avs_readdatavalid(rdv1), .avs_waitrequest(wq1),
        .ctrl_q(cq1), .ctrl_wr(cw1), .status_d(status_d), .event_in(event_in), .irq(irq1));

    avalon_mm_regbank #(.READ_LATENCY(2)) u2 (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_byteenable(avs_byteenable),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(rdd2), .avs_readdatavalid(rdv2), .avs_waitrequest(wq2),
        .ctrl_q(cq2), .ctrl_wr(cw2), .status_d(status_d), .event_in(event_in), .irq(irq2));

    avalon_mm_regbank #(.READ_LATENCY(3)) u3 (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_byteenable(avs_byteenable),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(rdd3), .avs_readdatavalid(rdv3), .avs_waitrequest(wq3),
        .ctrl_q(cq3), .ctrl_wr(cw3), .status_d(status_d), .event_in(event_in), .irq(irq3));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // word index of a byte address, or -1 for anything outside the 9-word window
    function automatic int word_of(input logic [31:0] a);
        longint off = longint'(a) - longint'(BASE);
        if (off < 0 || off % 4 != 0 || off / 4 >= 9) return -1;
        return int'(off / 4);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int i = word_of(a);
        if (i == 0) return ID;
        if (i == 1) return m_event;
        if (i == 2) return m_mask;
        if (i >= 3 && i <= 6) return m_ctrl[i-3];
        if (i >= 7) return status_d[(i-7)*32 +: 32];
        return 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, output logic [31:0] clr);
        int i = word_of(a);
        logic [31:0] bm;
        for (int b = 0; b < 4; b++) bm[b*8 +: 8] = be[b] ? 8'hFF : 8'h00;
        clr = 32'h0;
        if (i == 1) clr = d & bm;
        if (i == 2) m_mask = (m_mask & ~bm) | (d & bm);
        if (i >= 3 && i <= 6) begin
            m_ctrl[i-3] = (m_ctrl[i-3] & ~bm) | (d & bm);
            m_wr[i-3]   = |be;
        end
    endtask

    task automatic model_reset();
        m_event = 0; m_mask = 0; m_ctrl = 0; m_wr = 0; m_irq = 0; m_wait = 1;
        foreach (hv[j]) hv[j] = 1'b0;
        for (int l = 1; l <= 3; l++) m_rd[l] = 0;
    endtask

    task automatic chk_inst(input string n, input logic w, input logic i, input logic [3:0] cw,
                            input logic [127:0] cq, input logic v, input logic [31:0] d, input int l);
        chk({n, "_waitreq"}, w, m_wait);
        chk({n, "_irq"}, i, m_irq);
        chk({n, "_ctrl_wr"}, cw, m_wr);
        chk({n, "_ctrl_q"}, cq, m_ctrl);
        chk({n, "_valid"}, v, (cyc >= l) ? hv[cyc-l] : 1'b0);
        chk({n, "_rdata"}, d, m_rd[l]);
    endtask

    task automatic check_all();
        chk_inst("lat1", wq1, irq1, cw1, cq1, rdv1, rdd1, 1);
        chk_inst("lat2", wq2, irq2, cw2, cq2, rdv2, rdd2, 2);
        chk_inst("lat3", wq3, irq3, cw3, cq3, rdv3, rdd3, 3);
    endtask

    task automatic tick();
        logic [31:0] clr;
        logic acc_r, acc_w;
        @(posedge clk);
        if (!reset_n) model_reset();
        else begin
            acc_r   = avs_read && !m_wait;
            acc_w   = avs_write && !m_wait;
            hv[cyc] = acc_r;
            hd[cyc] = acc_r ? model_read(avs_address) : 32'h0;
            m_irq   = |(m_event & m_mask);
            m_wr    = 0;
            clr     = 0;
            if (acc_w) model_write(avs_address, avs_writedata, avs_byteenable, clr);
            m_event = (m_event & ~clr) | event_in;
            m_wait  = 0;
        end
        cyc++;
        for (int l = 1; l <= 3; l++) if (cyc >= l && hv[cyc-l]) m_rd[l] = hd[cyc-l];
        #1;
        check_all();
        status_d = {$urandom, $urandom};
    endtask

    task automatic rd(input logic [31:0] a);
        avs_read = 1; avs_address = a;
        tick();
        avs_read = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_write = 1; avs_address = a; avs_writedata = d; avs_byteenable = be;
        tick();
        avs_write = 0;
    endtask

    function automatic logic [31:0] rand_addr();
        int k = $urandom_range(0, 15);
        if (k < 11) return BASE + 32'(4 * k);
        if (k < 13) return BASE + 32'(4 * $urandom_range(0, 8) + $urandom_range(1, 3));
        if (k < 15) return BASE - 32'(4 * $urandom_range(1, 20));
        return BASE + 32'(4 * $urandom_range(11, 1000));
    endfunction

    initial begin
        clk = 0; reset_n = 1; avs_read = 0; avs_write = 0; avs_address = 0;
        avs_writedata = 0; avs_byteenable = 0; event_in = 0; status_d = {$urandom, $urandom};
        model_reset();
        #2 reset_n = 0;
        #1 check_all();
        repeat (3) tick();
        reset_n = 1;
        chk("wait_at_release", wq1, 1'b1);
        tick();
        chk("wait_after_edge", wq1, 1'b0);

        rd(BASE);
        chk("id_valid", rdv1, 1'b1);
        chk("id_data", rdd1, ID);
        repeat (3) tick();

        wr(BASE + 12, 32'hAABBCCDD, 4'b0101);
        chk("ctrl0_value", cq1[31:0], 32'h00BB00DD);
        chk("ctrl0_wr_pulse", cw1, 4'b0001);
        tick();
        chk("ctrl0_wr_drop", cw1, 4'b0000);
        rd(BASE + 12);
        chk("ctrl0_readback", rdd1, 32'h00BB00DD);

        wr(BASE + 8, 32'h1, 4'hF);
        event_in = 32'h11;
        tick();
        event_in = 0;
        chk("irq_lags_event", irq1, 1'b0);
        tick();
        chk("irq_set", irq1, 1'b1);
        rd(BASE + 4);
        chk("event_set", rdd1, 32'h11);
        event_in = 32'h1;
        wr(BASE + 4, 32'h1, 4'hF);
        event_in = 0;
        rd(BASE + 4);
        chk("event_set_wins", rdd1, 32'h11);
        wr(BASE + 4, 32'h11, 4'hF);
        tick();
        chk("irq_cleared", irq1, 1'b0);
        rd(BASE + 4);
        chk("event_cleared", rdd1, 32'h0);

        avs_read = 1;
        avs_address = BASE;      tick();
        avs_address = BASE + 8;  tick();
        avs_address = BASE + 28; tick();
        chk("b2b_first_lat3", rdd3, ID);
        avs_address = BASE + 32; tick();
        avs_read = 0;
        repeat (4) tick();

        rd(BASE + 2);
        chk("miss_unaligned_valid", rdv1, 1'b1);
        chk("miss_unaligned_data", rdd1, 32'h0);
        rd(32'h11223300);
        chk("miss_below_data", rdd1, 32'h0);
        rd(BASE + 36);
        chk("miss_beyond_valid", rdv1, 1'b1);
        chk("miss_beyond_data", rdd1, 32'h0);
        wr(BASE + 2, 32'hFFFFFFFF, 4'hF);
        wr(32'h11223300, 32'hFFFFFFFF, 4'hF);
        wr(BASE + 36, 32'hFFFFFFFF, 4'hF);
        chk("miss_no_ctrl_wr", cw1, 4'b0000);
        repeat (3) tick();

        rd(BASE);
        reset_n = 0;
        model_reset();
        #1 check_all();
        repeat (2) tick();
        reset_n = 1;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("flush_valid_lat2", rdv2, 1'b0);
        end
        chk("ctrl_after_reset", cq2, 128'h0);

        for (int n = 0; n < 500; n++) begin
            int r = $urandom_range(0, 9);
            avs_read       = (r < 4) || (r == 9);
            avs_write      = (r >= 4 && r < 8) || (r == 9);
            avs_address    = rand_addr();
            avs_writedata  = $urandom;
            avs_byteenable = 4'($urandom);
            event_in       = ($urandom_range(0, 7) == 0) ? ($urandom & 32'h0000_0F0F) : 32'h0;
            tick();
        end
        avs_read = 0; avs_write = 0; event_in = 0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
